// File: rtl/tx_reply_arbiter.sv
// Shares one TX byte path among N reply engines; round-robin, or fixed priority with TX_ARB_FIXED_PRIO_EN.
// Latency: strobe 1 cycle after the grant decision, tx_valid DATA_LAT+1 cycles after the first strobe.
// Backpressure: none downstream; requests are latched in pend and served one frame at a time.
module tx_reply_arbiter #(
  parameter int N_CLIENT = 4,
  parameter int LEN_W    = 11,
  parameter int DATA_LAT = 2,
  parameter int IFG      = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CLIENT-1:0]       req,
  input  logic [N_CLIENT*LEN_W-1:0] len_i,
  input  logic [N_CLIENT*8-1:0]     data_i,
  output logic [N_CLIENT-1:0]       strobe_o,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  output logic                      busy,
  output logic [2:0]                grant_idx
);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, GAP} state_t;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    cnt, cnt_nxt;
  logic [2:0]          gidx_nxt;
  logic [2:0]          winner;
  logic [LEN_W-1:0]    win_len;
  logic [7:0]          sel_dat;
  logic [N_CLIENT-1:0] pend, pend_clr;
  logic [DATA_LAT-1:0] stb_pipe;

`ifndef TX_ARB_FIXED_PRIO_EN
  logic [2:0]          rr, rr_nxt;
`endif

  // Lowest pending index wins; in round-robin mode the lowest index above rr overrides it.
  always_comb begin
    winner = '0;
    for (int i = N_CLIENT - 1; i >= 0; i--) begin
      if (pend[i]) winner = 3'(i);
    end
`ifndef TX_ARB_FIXED_PRIO_EN
    for (int i = N_CLIENT - 1; i >= 0; i--) begin
      if (pend[i] && (3'(i) > rr)) winner = 3'(i);
    end
`endif
  end

  always_comb begin
    win_len = '0;
    sel_dat = '0;
    for (int i = 0; i < N_CLIENT; i++) begin
      if (winner == 3'(i))    win_len = len_i[i*LEN_W +: LEN_W];
      if (grant_idx == 3'(i)) sel_dat = data_i[i*8 +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gidx_nxt  = grant_idx;
    pend_clr  = '0;
    strobe_o  = '0;
`ifndef TX_ARB_FIXED_PRIO_EN
    rr_nxt    = rr;
`endif
    case (state)
      IDLE: begin
        if (|pend) begin
          gidx_nxt = winner;
`ifndef TX_ARB_FIXED_PRIO_EN
          rr_nxt   = winner;
`endif
          pend_clr = N_CLIENT'(1) << winner;
          cnt_nxt  = win_len;
          // A zero-length reply is consumed without a strobe or a gap.
          if (win_len != '0) state_nxt = GRANT;
        end
      end
      GRANT: begin
        strobe_o = N_CLIENT'(1) << grant_idx;
        cnt_nxt  = cnt - LEN_W'(1);
        if (cnt == LEN_W'(1)) begin
          state_nxt = DRAIN;
          cnt_nxt   = LEN_W'(DATA_LAT);
        end
      end
      DRAIN: begin
        cnt_nxt = cnt - LEN_W'(1);
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = LEN_W'(IFG - 1);
        end
      end
      default: begin
        cnt_nxt = cnt - LEN_W'(1);
        if (cnt == '0) state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      grant_idx <= '0;
      pend      <= '0;
      stb_pipe  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
`ifndef TX_ARB_FIXED_PRIO_EN
      rr        <= 3'(N_CLIENT - 1);
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      grant_idx <= gidx_nxt;
      // A request in its own grant cycle re-arms pend for the next round.
      pend      <= (pend & ~pend_clr) | req;
      stb_pipe[0] <= |strobe_o;
      for (int i = 1; i < DATA_LAT; i++) stb_pipe[i] <= stb_pipe[i-1];
      tx_valid  <= stb_pipe[DATA_LAT-1];
      tx_data   <= stb_pipe[DATA_LAT-1] ? sel_dat : 8'h00;
`ifndef TX_ARB_FIXED_PRIO_EN
      rr        <= rr_nxt;
`endif
    end
  end

endmodule
